// File: rtl/max_pool1d.sv
// max_pool1d: temporal max-pool with fused ReLU.
//
// Each lane independently reduces every POOL_SIZE consecutive accepted beats to their signed
// maximum and clamps negatives to zero. The last window of a frame may be partial. A frame ends
// on last_i or after FRAME_SIZE accepted beats, whichever comes first.
//
// Ports:
//   clk_i    clock
//   rst_i    asynchronous reset, active-high
//   data_i   input vector, lane k at [k*BW +: BW], signed
//   valid_i  input beat valid
//   last_i   final beat of the input frame
//   ready_o  block can accept an input beat
//   data_o   pooled, ReLU'd vector (each lane in [0, 2^(BW-1)-1])
//   valid_o  output beat valid
//   last_o   final beat of the output frame
//   ready_i  downstream accepts the output beat
module max_pool1d #(
    parameter int unsigned FRAME_SIZE  = 50,
    parameter int unsigned VECTOR_SIZE = 8,
    parameter int unsigned BW          = 8,
    parameter int unsigned POOL_SIZE   = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [VECTOR_SIZE*BW-1:0]   data_i,
    input  logic                        valid_i,
    input  logic                        last_i,
    output logic                        ready_o,
    output logic [VECTOR_SIZE*BW-1:0]   data_o,
    output logic                        valid_o,
    output logic                        last_o,
    input  logic                        ready_i
);

    localparam int unsigned VW    = VECTOR_SIZE * BW;
    localparam int unsigned WIN_W = $clog2(POOL_SIZE);
    localparam int unsigned FRM_W = $clog2(FRAME_SIZE);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL_SIZE - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_SIZE - 1);

    logic [VW-1:0]    r_acc;
    logic [WIN_W-1:0] r_win_cnt;
    logic [FRM_W-1:0] r_frm_cnt;
    logic [VW-1:0]    r_data_o;
    logic             r_valid_o;
    logic             r_last_o;

    logic             w_accept;
    logic             w_first;
    logic             w_frame_end;
    logic             w_close;
    logic [VW-1:0]    w_max_vec;
    logic [VW-1:0]    w_relu_vec;

    // Output register empty or draining this cycle; held low throughout reset.
    assign ready_o     = !rst_i && (!r_valid_o || ready_i);
    assign w_accept    = valid_i && ready_o;
    // win_cnt == 0 is the "first beat of window" state: load instead of compare.
    assign w_first     = (r_win_cnt == '0);
    // A missing last_i is tolerated by forcing frame end on the FRAME_SIZE-th beat.
    assign w_frame_end = last_i || (r_frm_cnt == FRM_LAST);
    assign w_close     = (r_win_cnt == WIN_LAST) || w_frame_end;

    for (genvar k = 0; k < VECTOR_SIZE; k++) begin : g_lane
        logic signed [BW-1:0] w_in;
        logic signed [BW-1:0] w_acc;
        logic signed [BW-1:0] w_max;

        assign w_in  = data_i[k*BW +: BW];
        assign w_acc = r_acc[k*BW +: BW];
        assign w_max = (w_first || (w_in > w_acc)) ? w_in : w_acc;

        assign w_max_vec[k*BW +: BW]  = w_max;
        // ReLU on the sign bit; cannot overflow since the positive range is unchanged.
        assign w_relu_vec[k*BW +: BW] = w_max[BW-1] ? '0 : w_max;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc     <= '0;
            r_win_cnt <= '0;
            r_frm_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_max_vec;
            if (w_frame_end) begin
                r_win_cnt <= '0;
                r_frm_cnt <= '0;
            end else begin
                r_frm_cnt <= r_frm_cnt + 1'b1;
                r_win_cnt <= w_close ? '0 : r_win_cnt + 1'b1;
            end
        end
    end

    // Single-entry output register. A closing accept reloads it even while the current
    // entry drains, so back-to-back windows see no bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data_o  <= '0;
            r_valid_o <= 1'b0;
            r_last_o  <= 1'b0;
        end else if (w_accept && w_close) begin
            r_data_o  <= w_relu_vec;
            r_valid_o <= 1'b1;
            r_last_o  <= w_frame_end;
        end else if (ready_i) begin
            r_valid_o <= 1'b0;
        end
    end

    assign data_o  = r_data_o;
    assign valid_o = r_valid_o;
    assign last_o  = r_last_o;

endmodule

// File: tb/tb_max_pool1d.sv
// Scoreboard bench for max_pool1d: random beats, random backpressure, random mid-frame resets.
// The reference model buffers each frame's beats and computes window maxima directly.
module tb_max_pool1d;

    localparam int unsigned FRAME_SIZE  = 7;
    localparam int unsigned VECTOR_SIZE = 4;
    localparam int unsigned BW          = 8;
    localparam int unsigned POOL_SIZE   = 3;
    localparam int unsigned VW          = VECTOR_SIZE * BW;

    typedef struct packed {
        logic [VW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk;
    logic          rst_i;
    logic [VW-1:0] data_i;
    logic          valid_i;
    logic          last_i;
    logic          ready_o;
    logic [VW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_i;

    exp_t          exp_q[$];
    logic [VW-1:0] frm_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic          held_v = 1'b0;
    logic [VW-1:0] held_d;
    logic          held_l;

    max_pool1d #(
        .FRAME_SIZE (FRAME_SIZE),
        .VECTOR_SIZE(VECTOR_SIZE),
        .BW         (BW),
        .POOL_SIZE  (POOL_SIZE)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .data_i (data_i),
        .valid_i(valid_i),
        .last_i (last_i),
        .ready_o(ready_o),
        .data_o (data_o),
        .valid_o(valid_o),
        .last_o (last_o),
        .ready_i(ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    // Reference: on every accepted beat, close a window when POOL_SIZE beats have gathered
    // since the frame started (or the frame ends) and push max(0, max over the window).
    function automatic void model_accept(input logic [VW-1:0] d, input logic l);
        int   n;
        int   start;
        logic fe;
        exp_t e;
        frm_q.push_back(d);
        n  = frm_q.size();
        fe = l || (n == FRAME_SIZE);
        if ((n % POOL_SIZE) == 0 || fe) begin
            start = ((n - 1) / POOL_SIZE) * POOL_SIZE;
            e.d   = '0;
            e.l   = fe;
            for (int k = 0; k < VECTOR_SIZE; k++) begin
                int m = -100000;
                for (int i = start; i < n; i++) begin
                    logic [VW-1:0]        b;
                    logic signed [BW-1:0] lv;
                    b  = frm_q[i];
                    lv = b[k*BW +: BW];
                    if (int'(lv) > m) m = int'(lv);
                end
                if (m < 0) m = 0;
                e.d[k*BW +: BW] = BW'(m);
            end
            exp_q.push_back(e);
        end
        if (fe) frm_q.delete();
    endfunction

    task automatic cycle(input logic v, input logic [VW-1:0] d, input logic l, input logic r);
        @(posedge clk);
        #1;
        valid_i = v;
        data_i  = d;
        last_i  = l;
        ready_i = r;
        @(negedge clk);
        if (v && ready_o) model_accept(d, l);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        exp_q.delete();
        frm_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(ready_o), 64'd1);
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < VECTOR_SIZE; k++) begin
            case ($urandom_range(0, 7))
                0:       v[k*BW +: BW] = 8'h80;
                1:       v[k*BW +: BW] = 8'h7f;
                2:       v[k*BW +: BW] = 8'h00;
                default: v[k*BW +: BW] = BW'($urandom);
            endcase
        end
        return v;
    endfunction

    // Monitor: compare every consumed output beat against the scoreboard and check hold.
    always @(negedge clk) begin
        if (rst_i) begin
            check("reset_valid_o", 64'(valid_o), 64'd0);
            check("reset_data_o", 64'(data_o), 64'd0);
            check("reset_last_o", 64'(last_o), 64'd0);
            check("reset_ready_o", 64'(ready_o), 64'd0);
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", 64'(valid_o), 64'd1);
                check("hold_data", 64'(data_o), 64'(held_d));
                check("hold_last", 64'(last_o), 64'(held_l));
                check("stall_ready_o", 64'(ready_o), 64'(ready_i));
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(valid_o), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(data_o), 64'(e.d));
                    check("out_last", 64'(last_o), 64'(e.l));
                end
            end
            held_v = valid_o && !ready_i;
            held_d = data_o;
            held_l = last_o;
        end
    end

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        last_i  = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(ready_o), 64'd1);

        // Directed: one beat of a window, reset, then a fresh two-beat frame.
        cycle(1'b1, VW'(100), 1'b0, 1'b1);
        do_reset();
        cycle(1'b1, VW'(1), 1'b0, 1'b1);
        cycle(1'b1, VW'(2), 1'b1, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);
        check("directed_drained", 64'(exp_q.size()), 64'd0);

        // Directed: full frame with no last_i at full throughput.
        for (int i = 0; i < int'(FRAME_SIZE); i++) cycle(1'b1, rand_vec(), 1'b0, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);
        check("noflast_drained", 64'(exp_q.size()), 64'd0);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            logic v, l, r;
            v = ($urandom_range(0, 9) < 8);
            l = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 9) < 7);
            cycle(v, rand_vec(), l, r);
            if ((i % 400) == 399) do_reset();
        end

        repeat (10) cycle(1'b0, '0, 1'b0, 1'b1);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
